// File: rtl/sfu_out_packer.sv
// sfu_out_packer: drains the SFU output FIFO, packs PACK_FACTOR elements per
// wide beat and streams the beats out on a valid/ready interface.
module sfu_out_packer #(
  parameter int DATA_WIDTH  = 32,
  parameter int PACK_FACTOR = 4,
  parameter int LEN_WIDTH   = 16
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              start,
  input  logic [LEN_WIDTH-1:0]              num_elems,
  output logic                              busy,
  output logic                              done,
  output logic                              fifo_rd_en,
  input  logic [DATA_WIDTH-1:0]             fifo_data,
  input  logic                              fifo_data_valid,
  output logic [DATA_WIDTH*PACK_FACTOR-1:0] m_data,
  output logic [PACK_FACTOR-1:0]            m_strb,
  output logic                              m_last,
  output logic                              m_valid,
  input  logic                              m_ready
);

  localparam int CW = $clog2(PACK_FACTOR + 1);

  typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_WAIT_OUT, S_DONE} state_t;

  state_t                               state_reg, state_next;
  logic [LEN_WIDTH-1:0]                 num_reg, rcvd_reg;
  logic [CW-1:0]                        pack_cnt_reg, pack_cnt_next, wr_lane;
  logic                                 inflight_reg;
  logic [DATA_WIDTH-1:0]                pack_mem [PACK_FACTOR];
  logic [DATA_WIDTH*PACK_FACTOR-1:0]    beat_data;
  logic [PACK_FACTOR-1:0]               beat_strb;
  logic [DATA_WIDTH*PACK_FACTOR-1:0]    m_data_reg;
  logic [PACK_FACTOR-1:0]               m_strb_reg;
  logic                                 m_last_reg, m_valid_reg;
  logic                                 accept, all_rcvd, flush_req, out_free, xfer;

  // Element accept / pack flush decisions, all from registered state.
  always_comb begin
    accept        = (state_reg == S_DRAIN) && inflight_reg && fifo_data_valid;
    all_rcvd      = (rcvd_reg == num_reg);
    flush_req     = (state_reg == S_DRAIN) &&
                    ((pack_cnt_reg == CW'(PACK_FACTOR)) || (all_rcvd && (pack_cnt_reg != '0)));
    out_free      = !m_valid_reg || m_ready;
    xfer          = flush_req && out_free;
    // An element arriving while the pack is handed off starts the new pack.
    wr_lane       = xfer ? '0 : pack_cnt_reg;
    pack_cnt_next = wr_lane + CW'(accept);
  end

  // Lanes beyond the fill level are zeroed and unstrobed in the outgoing beat.
  for (genvar gi = 0; gi < PACK_FACTOR; gi++) begin : g_lane
    assign beat_strb[gi] = (CW'(gi) < pack_cnt_reg);
    assign beat_data[gi*DATA_WIDTH +: DATA_WIDTH] = beat_strb[gi] ? pack_mem[gi] : '0;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= S_IDLE;
    else        state_reg <= state_next;
  end

  // Next state plus state-decoded outputs; at most one read outstanding.
  always_comb begin
    state_next = state_reg;
    busy       = 1'b0;
    done       = 1'b0;
    fifo_rd_en = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (start) state_next = (num_elems == '0) ? S_DONE : S_DRAIN;
      end
      S_DRAIN: begin
        busy       = 1'b1;
        fifo_rd_en = (({1'b0, rcvd_reg} + {{LEN_WIDTH{1'b0}}, inflight_reg}) < {1'b0, num_reg}) &&
                     (({1'b0, pack_cnt_reg} + {{CW{1'b0}}, inflight_reg}) < (CW+1)'(PACK_FACTOR));
        if (xfer && all_rcvd) state_next = S_WAIT_OUT;
      end
      S_WAIT_OUT: begin
        busy = 1'b1;
        if (m_valid_reg && m_ready && m_last_reg) state_next = S_DONE;
      end
      S_DONE: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Job length, element counters and the outstanding-read flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      num_reg      <= '0;
      rcvd_reg     <= '0;
      pack_cnt_reg <= '0;
      inflight_reg <= 1'b0;
    end else begin
      inflight_reg <= fifo_rd_en;
      if (state_reg == S_IDLE && start) begin
        num_reg      <= num_elems;
        rcvd_reg     <= '0;
        pack_cnt_reg <= '0;
      end else if (state_reg == S_DRAIN) begin
        if (accept) rcvd_reg <= rcvd_reg + LEN_WIDTH'(1);
        pack_cnt_reg <= pack_cnt_next;
      end
    end
  end

  // Pack buffer: accepted element lands in its lane.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < PACK_FACTOR; i++) pack_mem[i] <= '0;
    end else if (accept) begin
      for (int i = 0; i < PACK_FACTOR; i++) begin
        if (wr_lane == CW'(i)) pack_mem[i] <= fifo_data;
      end
    end
  end

  // Output register: loads a beat when free, holds it until handshaken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_data_reg  <= '0;
      m_strb_reg  <= '0;
      m_last_reg  <= 1'b0;
      m_valid_reg <= 1'b0;
    end else if (xfer) begin
      m_data_reg  <= beat_data;
      m_strb_reg  <= beat_strb;
      m_last_reg  <= all_rcvd;
      m_valid_reg <= 1'b1;
    end else if (m_valid_reg && m_ready) begin
      m_valid_reg <= 1'b0;
      m_last_reg  <= 1'b0;
    end
  end

  assign m_data  = m_data_reg;
  assign m_strb  = m_strb_reg;
  assign m_last  = m_last_reg;
  assign m_valid = m_valid_reg;

endmodule
